// File: rtl/rx_3of6_assembler.sv
// ---------------------------------------------------------------------------
// rx_3of6_assembler
//
// Receives a 4-phase return-to-zero 3-of-6 link one symbol at a time and
// packs eight symbols into a 48-bit word for the downstream 3-of-6 decoder.
// The first symbol of a word lands in encoded[5:0], the eighth in [47:42].
//
// Link protocol: a codeword appears on sym_in, is accepted once it has been
// seen unchanged on two consecutive samples, and is acknowledged by raising
// sym_ack. The sender then returns the wires to the all-zero spacer; after
// two consecutive zero samples sym_ack falls and the next symbol may follow.
//
// The output side is a one-word valid/ready slot. Symbols 1-7 are never held
// up by it. The eighth symbol is only accepted when the slot can take the
// completed word; until then it is left unacknowledged, which stalls the
// link.
//
// Build option:
//   RX_SYNC_EN  when defined, every sym_in bit passes through a 2-flop
//               synchronizer before it reaches the FSM, adding two cycles to
//               every link-side latency. Undefined by default, in which case
//               sym_in feeds the FSM directly.
// ---------------------------------------------------------------------------
module rx_3of6_assembler (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  sym_in,
  output logic        sym_ack,
  output logic [47:0] encoded,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [2:0]  sym_cnt,
  output logic [15:0] word_cnt
);

  // DATA waits for a stable codeword, SPACER waits for a stable all-zero.
  typedef enum logic {
    ST_DATA   = 1'b0,
    ST_SPACER = 1'b1
  } state_t;

  // Number of ones in a 6-bit link sample.
  function automatic logic [2:0] popcount6(input logic [5:0] v);
    logic [2:0] cnt;
    cnt = 3'd0;
    for (int i = 0; i < 6; i++) begin
      cnt = cnt + {2'b00, v[i]};
    end
    return cnt;
  endfunction

  state_t      r_state;
  state_t      w_state_nxt;

  logic [5:0]  w_s;          // link sample seen by the FSM
  logic [5:0]  r_prev_s;     // previous cycle's link sample
  logic        r_sym_ack;
  logic [47:0] r_asm_reg;    // word under assembly
  logic [2:0]  r_sym_cnt;
  logic [47:0] r_encoded;
  logic        r_out_valid;
  logic [15:0] r_word_cnt;

  logic        w_stable;
  logic        w_is_code;
  logic        w_is_spacer;
  logic        w_last_sym;
  logic        w_slot_free;
  logic        w_handoff;
  logic        w_accept;
  logic        w_release;
  logic        w_load;
  logic [47:0] w_asm_next;

`ifdef RX_SYNC_EN
  logic [5:0]  r_sync_meta;
  logic [5:0]  r_sync_out;

  // Two-flop synchronizer per link wire; the link is asynchronous to clk.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync_meta <= 6'd0;
      r_sync_out  <= 6'd0;
    end else begin
      // NOTE: non-blocking assignments let both stages sample the old value
      // of their source on the same edge; blocking ones would collapse the
      // chain into a single flop.
      r_sync_meta <= sym_in;
      r_sync_out  <= r_sync_meta;
    end
  end

  assign w_s = r_sync_out;
`else
  assign w_s = sym_in;
`endif

  // Sample qualification and output-slot status.
  assign w_stable    = (w_s == r_prev_s);
  assign w_is_code   = (popcount6(w_s) >= 3'd3);
  assign w_is_spacer = (w_s == 6'd0) && (r_prev_s == 6'd0);
  assign w_last_sym  = (r_sym_cnt == 3'd7);
  assign w_slot_free = !r_out_valid || out_ready;
  assign w_handoff   = r_out_valid && out_ready;

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_DATA;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next state and the accept/release strobes that drive the datapath.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // leaves one unassigned and no latch is inferred.
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_release   = 1'b0;
    case (r_state)
      ST_DATA: begin
        // Popcount 1-2 is a link still in transition and is ignored;
        // popcount 4+ is passed through for the decoder to flag. The eighth
        // symbol additionally needs somewhere to put the finished word.
        if (w_is_code && w_stable && (!w_last_sym || w_slot_free)) begin
          w_accept    = 1'b1;
          w_state_nxt = ST_SPACER;
        end
      end
      ST_SPACER: begin
        if (w_is_spacer) begin
          w_release   = 1'b1;
          w_state_nxt = ST_DATA;
        end
      end
      default: begin
        w_state_nxt = ST_DATA;
      end
    endcase
  end

  // Assembly register contents after writing the current sample into the
  // slot selected by the symbol count.
  always_comb begin
    w_asm_next = r_asm_reg;
    for (int i = 0; i < 8; i++) begin
      if (r_sym_cnt == 3'(i)) begin
        w_asm_next[6*i +: 6] = w_s;
      end
    end
  end

  // The eighth accepted symbol completes the word and loads the output slot.
  assign w_load = w_accept && w_last_sym;

  // Link-side datapath: previous sample, acknowledge, assembly and count.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the assembly register is a plain data register, but it is
      // cleared here so a partial word never survives a reset.
      r_prev_s  <= 6'd0;
      r_sym_ack <= 1'b0;
      r_asm_reg <= 48'd0;
      r_sym_cnt <= 3'd0;
    end else begin
      r_prev_s <= w_s;
      if (w_accept) begin
        r_asm_reg <= w_asm_next;
        r_sym_cnt <= r_sym_cnt + 3'd1;   // 7 -> 0 closes the word
        r_sym_ack <= 1'b1;
      end else if (w_release) begin
        r_sym_ack <= 1'b0;
      end
    end
  end

  // Output slot: load on word completion, drain on valid && ready, and
  // count every word handed off.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_encoded   <= 48'd0;
      r_out_valid <= 1'b0;
      r_word_cnt  <= 16'd0;
    end else begin
      if (w_load) begin
        r_encoded   <= w_asm_next;
        r_out_valid <= 1'b1;
      end else if (w_handoff) begin
        r_out_valid <= 1'b0;
      end
      if (w_handoff) begin
        r_word_cnt <= r_word_cnt + 16'd1;  // wraps from 16'hFFFF to 0
      end
    end
  end

  assign sym_ack   = r_sym_ack;
  assign encoded   = r_encoded;
  assign out_valid = r_out_valid;
  assign sym_cnt   = r_sym_cnt;
  assign word_cnt  = r_word_cnt;

endmodule

// File: tb/tb_rx_3of6_assembler.sv
// ---------------------------------------------------------------------------
// tb_rx_3of6_assembler
//
// Drives the 4-phase 3-of-6 link and the output ready, and compares the
// assembler against a word-level reference: every acknowledged symbol is
// appended to a partial word with shift/or arithmetic, each completed word is
// queued, and every output handoff must match the head of that queue.
// Build with RX_SYNC_EN defined to check the synchronized variant.
// ---------------------------------------------------------------------------
module tb_rx_3of6_assembler;

`ifdef RX_SYNC_EN
  localparam int LINK_LAT = 4;
`else
  localparam int LINK_LAT = 2;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  sym_in;
  logic        sym_ack;
  logic [47:0] encoded;
  logic        out_valid;
  logic        out_ready;
  logic [2:0]  sym_cnt;
  logic [15:0] word_cnt;

  int          n_vectors     = 0;
  int          n_miscompares = 0;
  bit          rand_ready    = 1'b0;

  // Reference model state.
  logic [47:0] exp_q[$];
  logic [47:0] m_word     = 48'd0;
  int          m_cnt      = 0;
  logic [15:0] m_handoffs = 16'd0;

  // Output hold tracking.
  bit          hold_prev  = 1'b0;
  logic [47:0] hold_enc   = 48'd0;

  rx_3of6_assembler dut (
    .clk       (clk),
    .rst       (rst),
    .sym_in    (sym_in),
    .sym_ack   (sym_ack),
    .encoded   (encoded),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sym_cnt   (sym_cnt),
    .word_cnt  (word_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------- model
  task automatic model_clear();
    exp_q.delete();
    m_word     = 48'd0;
    m_cnt      = 0;
    m_handoffs = 16'd0;
  endtask

  task automatic model_accept(input logic [5:0] sym);
    m_word = m_word | (48'(sym) << (6 * m_cnt));
    m_cnt++;
    if (m_cnt == 8) begin
      exp_q.push_back(m_word);
      m_word = 48'd0;
      m_cnt  = 0;
    end
  endtask

  function automatic logic [5:0] rand_code();
    logic [5:0] v;
    v = 6'($urandom);
    if ($urandom_range(0, 7) == 0) begin
      while ($countones(v) < 3) v = 6'($urandom);
    end else begin
      while ($countones(v) != 3) v = 6'($urandom);
    end
    return v;
  endfunction

  // Output monitor: handoffs against the scoreboard, hold while stalled.
  always @(negedge clk) begin
    if (hold_prev) begin
      n_vectors++;
      if (out_valid !== 1'b1 || encoded !== hold_enc) begin
        n_miscompares++;
        $display("FAIL hold: out_valid=%b encoded=%h required out_valid=1 encoded=%h",
                 out_valid, encoded, hold_enc);
      end
    end
    if (rst === 1'b0 && out_valid === 1'b1 && out_ready === 1'b1) begin
      n_vectors++;
      if (exp_q.size() == 0) begin
        n_miscompares++;
        $display("FAIL handoff_unexpected: encoded=%h with no word expected", encoded);
      end else begin
        logic [47:0] exp_w;
        exp_w = exp_q.pop_front();
        if (encoded !== exp_w) begin
          n_miscompares++;
          $display("FAIL handoff_word: encoded=%h required %h", encoded, exp_w);
        end
      end
      n_vectors++;
      if (word_cnt !== m_handoffs) begin
        n_miscompares++;
        $display("FAIL handoff_word_cnt: word_cnt=%0d required %0d", word_cnt, m_handoffs);
      end
      m_handoffs = m_handoffs + 16'd1;
    end
    hold_prev = (rst === 1'b0 && out_valid === 1'b1 && out_ready === 1'b0);
    hold_enc  = encoded;
  end

  // ---------------------------------------------------------------- driver
  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_ready) out_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst    = 1'b1;
    sym_in = 6'd0;
    model_clear();
    tick();
    rst = 1'b0;
  endtask

  task automatic expect_bit(input string name, input logic act, input logic req);
    n_vectors++;
    if (act !== req) begin
      n_miscompares++;
      $display("FAIL %s: got %b required %b", name, act, req);
    end
  endtask

  task automatic wait_ack_low();
    int n;
    n = 0;
    while (sym_ack !== 1'b0 && n < 400) begin
      tick();
      n++;
    end
    expect_bit("ack_fall", sym_ack, 1'b0);
  endtask

  // One full 4-phase transfer, optionally preceded by a 1-cycle transient.
  task automatic send_symbol(input logic [5:0] sym, input bit glitch, input logic [5:0] gval);
    int n;
    if (glitch) begin
      sym_in = gval;
      tick();
    end
    sym_in = sym;
    n = 0;
    while (sym_ack !== 1'b1 && n < 400) begin
      tick();
      n++;
    end
    expect_bit("ack_rise", sym_ack, 1'b1);
    if (sym_ack !== 1'b1) begin
      sym_in = 6'd0;
      return;
    end
    model_accept(sym);
    n_vectors++;
    if (sym_cnt !== 3'(m_cnt)) begin
      n_miscompares++;
      $display("FAIL sym_cnt_after_ack: got %0d required %0d", sym_cnt, m_cnt);
    end
    sym_in = 6'd0;
    wait_ack_low();
  endtask

  // ---------------------------------------------------------------- tests
  task automatic test_reset();
    rst       = 1'b1;
    sym_in    = 6'd0;
    out_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    model_clear();
    expect_bit("reset_sym_ack", sym_ack, 1'b0);
    expect_bit("reset_out_valid", out_valid, 1'b0);
    n_vectors++;
    if (sym_cnt !== 3'd0 || word_cnt !== 16'd0 || encoded !== 48'd0) begin
      n_miscompares++;
      $display("FAIL reset_values: sym_cnt=%0d word_cnt=%0d encoded=%h required 0 0 0",
               sym_cnt, word_cnt, encoded);
    end
  endtask

  task automatic test_basic_word();
    int n;
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 7; i++) send_symbol(6'b000111, 1'b0, 6'd0);
    sym_in = 6'b000111;
    n = 0;
    while (out_valid !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    model_accept(6'b000111);
    n_vectors++;
    if (n != LINK_LAT) begin
      n_miscompares++;
      $display("FAIL basic_latency: out_valid after %0d cycles required %0d", n, LINK_LAT);
    end
    n_vectors++;
    if (encoded !== 48'h1C71C71C71C7) begin
      n_miscompares++;
      $display("FAIL basic_encoded: got %h required 1c71c71c71c7", encoded);
    end
    expect_bit("basic_ack", sym_ack, 1'b1);
    tick();
    expect_bit("basic_valid_one_cycle", out_valid, 1'b0);
    n_vectors++;
    if (word_cnt !== 16'd1) begin
      n_miscompares++;
      $display("FAIL basic_word_cnt: got %0d required 1", word_cnt);
    end
    sym_in = 6'd0;
    wait_ack_low();
  endtask

  task automatic test_glitch();
    do_reset();
    out_ready = 1'b1;
    sym_in    = 6'b000001;
    tick();
    n_vectors++;
    if (sym_cnt !== 3'd0) begin
      n_miscompares++;
      $display("FAIL glitch_no_capture: sym_cnt=%0d required 0", sym_cnt);
    end
    expect_bit("glitch_no_ack", sym_ack, 1'b0);
    send_symbol(6'b000111, 1'b0, 6'd0);
    n_vectors++;
    if (sym_cnt !== 3'd1) begin
      n_miscompares++;
      $display("FAIL glitch_single_capture: sym_cnt=%0d required 1", sym_cnt);
    end
    for (int i = 0; i < 7; i++) send_symbol(rand_code(), 1'b0, 6'd0);
    repeat (3) tick();
  endtask

  task automatic test_wide_code();
    do_reset();
    out_ready = 1'b0;
    send_symbol(6'b001111, 1'b0, 6'd0);
    for (int i = 0; i < 7; i++) send_symbol(6'b000111, 1'b0, 6'd0);
    expect_bit("wide_valid", out_valid, 1'b1);
    n_vectors++;
    if (encoded[5:0] !== 6'b001111) begin
      n_miscompares++;
      $display("FAIL wide_slot0: got %b required 001111", encoded[5:0]);
    end
    out_ready = 1'b1;
    tick();
    tick();
  endtask

  task automatic test_back_pressure();
    logic [5:0]  syms[16];
    logic [47:0] w1, w2;
    do_reset();
    out_ready = 1'b0;
    w1 = 48'd0;
    w2 = 48'd0;
    for (int i = 0; i < 16; i++) begin
      syms[i] = rand_code();
      if (i < 8) w1 = w1 | (48'(syms[i]) << (6 * i));
      else       w2 = w2 | (48'(syms[i]) << (6 * (i - 8)));
    end
    for (int i = 0; i < 15; i++) send_symbol(syms[i], 1'b0, 6'd0);
    expect_bit("bp_first_valid", out_valid, 1'b1);
    n_vectors++;
    if (sym_cnt !== 3'd7 || encoded !== w1) begin
      n_miscompares++;
      $display("FAIL bp_first_held: sym_cnt=%0d encoded=%h required 7 %h", sym_cnt, encoded, w1);
    end
    sym_in = syms[15];
    for (int i = 0; i < 10; i++) begin
      tick();
      expect_bit("bp_ack_stalled", sym_ack, 1'b0);
      n_vectors++;
      if (sym_cnt !== 3'd7) begin
        n_miscompares++;
        $display("FAIL bp_cnt_stalled: sym_cnt=%0d required 7", sym_cnt);
      end
    end
    out_ready = 1'b1;
    tick();
    model_accept(syms[15]);
    expect_bit("bp_ack_release", sym_ack, 1'b1);
    expect_bit("bp_valid_stays", out_valid, 1'b1);
    n_vectors++;
    if (encoded !== w2 || word_cnt !== 16'd1 || sym_cnt !== 3'd0) begin
      n_miscompares++;
      $display("FAIL bp_second_load: encoded=%h word_cnt=%0d sym_cnt=%0d required %h 1 0",
               encoded, word_cnt, sym_cnt, w2);
    end
    sym_in = 6'd0;
    tick();
    expect_bit("bp_drained", out_valid, 1'b0);
    n_vectors++;
    if (word_cnt !== 16'd2) begin
      n_miscompares++;
      $display("FAIL bp_word_cnt: got %0d required 2", word_cnt);
    end
    wait_ack_low();
  endtask

  task automatic test_reset_mid_word();
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) send_symbol(rand_code(), 1'b0, 6'd0);
    do_reset();
    n_vectors++;
    if (sym_cnt !== 3'd0) begin
      n_miscompares++;
      $display("FAIL midreset_cnt: sym_cnt=%0d required 0", sym_cnt);
    end
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) send_symbol(6'b111000, 1'b0, 6'd0);
    n_vectors++;
    if (out_valid !== 1'b1 || encoded !== 48'hE38E38E38E38) begin
      n_miscompares++;
      $display("FAIL midreset_word: out_valid=%b encoded=%h required 1 e38e38e38e38",
               out_valid, encoded);
    end
    out_ready = 1'b1;
    tick();
    n_vectors++;
    if (word_cnt !== 16'd1 || out_valid !== 1'b0) begin
      n_miscompares++;
      $display("FAIL midreset_handoff: word_cnt=%0d out_valid=%b required 1 0", word_cnt, out_valid);
    end
    // Reset while a word is waiting: it must be dropped, not counted.
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) send_symbol(rand_code(), 1'b0, 6'd0);
    expect_bit("drop_valid_before", out_valid, 1'b1);
    rst       = 1'b1;
    out_ready = 1'b1;
    model_clear();
    tick();
    rst = 1'b0;
    tick();
    expect_bit("drop_valid_after", out_valid, 1'b0);
    n_vectors++;
    if (word_cnt !== 16'd0 || encoded !== 48'd0) begin
      n_miscompares++;
      $display("FAIL drop_counts: word_cnt=%0d encoded=%h required 0 0", word_cnt, encoded);
    end
  endtask

  task automatic test_random();
    logic [5:0] sym, gval;
    bit         glitch;
    int         n;
    do_reset();
    rand_ready = 1'b1;
    for (int i = 0; i < 48; i++) begin
      sym    = rand_code();
      glitch = 1'($urandom_range(0, 1));
      gval   = sym & 6'($urandom);
      if (gval == sym) gval = 6'd0;
      send_symbol(sym, glitch, gval);
    end
    rand_ready = 1'b0;
    out_ready  = 1'b1;
    n = 0;
    while ((exp_q.size() != 0 || out_valid !== 1'b0) && n < 50) begin
      tick();
      n++;
    end
    n_vectors++;
    if (exp_q.size() != 0 || out_valid !== 1'b0 || sym_cnt !== 3'd0 || word_cnt !== 16'd6) begin
      n_miscompares++;
      $display("FAIL random_drain: pending=%0d out_valid=%b sym_cnt=%0d word_cnt=%0d required 0 0 0 6",
               exp_q.size(), out_valid, sym_cnt, word_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_basic_word();
    test_glitch();
    test_wide_code();
    test_back_pressure();
    test_reset_mid_word();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
    $finish;
  end

endmodule
